// File: rtl/prefetch_line_buffer.sv
// rtl/prefetch_line_buffer.sv - one-line prefetch buffer between I-cache miss port and memory
// Forwards demand misses, issues idle-time prefetches and serves matching misses from the held line.
module prefetch_line_buffer #(
  parameter int LINE_BITS = 256,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 prefetch_valid,
  input  logic [31:0]          prefetch_pc,
  input  logic                 pf_flush,
  input  logic [31:0]          ufp_addr,
  input  logic                 ufp_read,
  output logic [LINE_BITS-1:0] ufp_rdata,
  output logic                 ufp_resp,
  output logic [31:0]          dfp_addr,
  output logic                 dfp_read,
  input  logic [LINE_BITS-1:0] dfp_rdata,
  input  logic                 dfp_resp,
  output logic [CNT_W-1:0]     pf_issued,
  output logic [CNT_W-1:0]     pf_hits
);

  typedef enum logic [1:0] {IDLE, DEMAND, PREFETCH, RESP} state_t;

  state_t               state_q, state_d;
  logic                 pend_v_q, pend_v_d;
  logic [26:0]          pend_tag_q, pend_tag_d;
  logic                 buf_v_q, buf_v_d;
  logic [26:0]          buf_tag_q, buf_tag_d;
  logic [LINE_BITS-1:0] buf_data_q, buf_data_d;
  logic                 promo_q, promo_d;
  logic                 discard_q, discard_d;
  logic [31:0]          dfp_addr_q, dfp_addr_d;
  logic                 dfp_read_q, dfp_read_d;
  logic [LINE_BITS-1:0] ufp_rdata_q, ufp_rdata_d;
  logic                 ufp_resp_q, ufp_resp_d;
  logic [CNT_W-1:0]     pf_issued_q, pf_issued_d;
  logic [CNT_W-1:0]     pf_hits_q, pf_hits_d;

  logic [26:0] req_tag, ufp_tag, fly_tag;
  logic        in_flight, in_flight_next, promo_hit, req_dup;
  logic        unused_bits;

  assign req_tag     = prefetch_pc[31:5];
  assign ufp_tag     = ufp_addr[31:5];
  assign fly_tag     = dfp_addr_q[31:5];
  assign unused_bits = &{1'b0, prefetch_pc[4:0], ufp_addr[4:0]};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (&x) ? x : x + CNT_W'(1);
  endfunction

  always_comb begin
    state_d     = state_q;
    pend_v_d    = pend_v_q;
    pend_tag_d  = pend_tag_q;
    buf_v_d     = buf_v_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;
    promo_d     = promo_q;
    discard_d   = discard_q;
    dfp_addr_d  = dfp_addr_q;
    dfp_read_d  = dfp_read_q;
    ufp_rdata_d = ufp_rdata_q;
    ufp_resp_d  = 1'b0;
    pf_issued_d = pf_issued_q;
    pf_hits_d   = pf_hits_q;

    in_flight = (state_q == DEMAND) || (state_q == PREFETCH);
    promo_hit = (state_q == PREFETCH) && ufp_read && (ufp_tag == fly_tag);

    case (state_q)
      IDLE: begin
        if (ufp_read) begin
          if (buf_v_q && (ufp_tag == buf_tag_q)) begin
            ufp_rdata_d = buf_data_q;
            ufp_resp_d  = 1'b1;
            pf_hits_d   = sat_inc(pf_hits_q);
            state_d     = RESP;
          end else begin
            dfp_addr_d = {ufp_tag, 5'b0};
            dfp_read_d = 1'b1;
            state_d    = DEMAND;
          end
        end else if (pend_v_q) begin
          dfp_addr_d  = {pend_tag_q, 5'b0};
          dfp_read_d  = 1'b1;
          pend_v_d    = 1'b0;
          pf_issued_d = sat_inc(pf_issued_q);
          state_d     = PREFETCH;
        end
      end
      DEMAND: begin
        if (dfp_resp) begin
          ufp_rdata_d = dfp_rdata;
          ufp_resp_d  = 1'b1;
          dfp_read_d  = 1'b0;
          state_d     = RESP;
        end
      end
      PREFETCH: begin
        if (promo_hit) promo_d = 1'b1;
        if (dfp_resp) begin
          dfp_read_d = 1'b0;
          // A flush landing in the response cycle discards the line too.
          if (!discard_q && !pf_flush) begin
            buf_data_d = dfp_rdata;
            buf_tag_d  = fly_tag;
            buf_v_d    = 1'b1;
          end
          if (promo_q || promo_hit) begin
            ufp_rdata_d = dfp_rdata;
            ufp_resp_d  = 1'b1;
            pf_hits_d   = sat_inc(pf_hits_q);
            state_d     = RESP;
          end else begin
            state_d = IDLE;
          end
          promo_d   = 1'b0;
          discard_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (pf_flush) begin
      pend_v_d = 1'b0;
      buf_v_d  = 1'b0;
      if ((state_q == PREFETCH) && !dfp_resp) discard_d = 1'b1;
    end

    // Drop requests already buffered, in flight, or being issued this edge.
    in_flight_next = (state_d == DEMAND) || (state_d == PREFETCH);
    req_dup = (buf_v_q && (req_tag == buf_tag_q)) ||
              (in_flight && (req_tag == fly_tag)) ||
              (in_flight_next && (req_tag == dfp_addr_d[31:5]));
    if (prefetch_valid && !pf_flush && !req_dup) begin
      pend_v_d   = 1'b1;
      pend_tag_d = req_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pend_v_q    <= 1'b0;
      pend_tag_q  <= '0;
      buf_v_q     <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
      promo_q     <= 1'b0;
      discard_q   <= 1'b0;
      dfp_addr_q  <= '0;
      dfp_read_q  <= 1'b0;
      ufp_rdata_q <= '0;
      ufp_resp_q  <= 1'b0;
      pf_issued_q <= '0;
      pf_hits_q   <= '0;
    end else begin
      state_q     <= state_d;
      pend_v_q    <= pend_v_d;
      pend_tag_q  <= pend_tag_d;
      buf_v_q     <= buf_v_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
      promo_q     <= promo_d;
      discard_q   <= discard_d;
      dfp_addr_q  <= dfp_addr_d;
      dfp_read_q  <= dfp_read_d;
      ufp_rdata_q <= ufp_rdata_d;
      ufp_resp_q  <= ufp_resp_d;
      pf_issued_q <= pf_issued_d;
      pf_hits_q   <= pf_hits_d;
    end
  end

  assign ufp_rdata = ufp_rdata_q;
  assign ufp_resp  = ufp_resp_q;
  assign dfp_addr  = dfp_addr_q;
  assign dfp_read  = dfp_read_q;
  assign pf_issued = pf_issued_q;
  assign pf_hits   = pf_hits_q;

endmodule

// File: doc/prefetch_line_buffer.md
# prefetch_line_buffer

Memory-side responder for the instruction prefetcher's `prefetch_valid`/`prefetch_pc` requests. It sits between the I-cache's downstream port and the memory adapter.
- Forwards I-cache demand misses to memory.
- When the memory port is idle, issues the requested next-line (or previous-line) prefetch.
- Holds one prefetched 32-byte line and answers a matching demand miss from that line without a memory access.

## Interface
Parameters:
- `LINE_BITS`, 256, cache line width in bits (32-byte line, offset bits [4:0]).
- `CNT_W`, 16, width of the saturating statistics counters.

Ports:
- `clk` in 1: sole clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `prefetch_valid` in 1: one-cycle prefetch request pulse.
- `prefetch_pc` in 32: prefetch line address; bits [4:0] are ignored.
- `pf_flush` in 1: discards the pending request and the buffered line (branch/redirect).
- `ufp_addr` in 32: I-cache miss address; line-aligned by this block.
- `ufp_read` in 1: I-cache miss request; held high until `ufp_resp`.
- `ufp_rdata` out LINE_BITS: line returned to the cache; registered.
- `ufp_resp` out 1: one-cycle response pulse; registered.
- `dfp_addr` out 32: memory read address; bits [4:0] are always 0.
- `dfp_read` out 1: memory read request; held until `dfp_resp`.
- `dfp_rdata` in LINE_BITS: memory line data; valid only in the `dfp_resp` cycle.
- `dfp_resp` in 1: memory response pulse.
- `pf_issued` out CNT_W: count of prefetches sent to memory; saturating.
- `pf_hits` out CNT_W: count of demand misses served by the buffer or a promoted prefetch; saturating.

## Operation
State:
- Pending request: `pend_v`, `pend_tag` [31:5].
- Line buffer: `buf_v`, `buf_tag`, `buf_data`.
- Flags: `promo`, `discard`.
- FSM states: IDLE, DEMAND, PREFETCH, RESP.

Request capture (every cycle, all states):
- On `prefetch_valid`, set `pend_tag` = `prefetch_pc[31:5]` and `pend_v` = 1. A new request overwrites an older pending one.
- The request is dropped if it equals `buf_tag` with `buf_v` set, or equals the tag currently in flight.

IDLE:
- `ufp_read` with `buf_v` and tag match: load `ufp_rdata` from `buf_data`, increment `pf_hits`, go to RESP. The buffer stays valid.
- `ufp_read` with no match: go to DEMAND with `dfp_addr` = {`ufp_addr[31:5]`, 5'b0}.
- Otherwise, if `pend_v`: go to PREFETCH with `dfp_addr` = {`pend_tag`, 5'b0}, clear `pend_v`, increment `pf_issued`.
- Demand always has priority over a pending prefetch.

DEMAND:
- `dfp_read` = 1.
- On `dfp_resp`: register `dfp_rdata` into `ufp_rdata`, go to RESP.
- Demand data is never installed in the buffer.

PREFETCH:
- `dfp_read` = 1. The read is never aborted.
- If `ufp_read` arrives with a tag equal to the in-flight tag, set `promo`.
- On `dfp_resp`:
  - If not `discard`: write `buf_data`/`buf_tag`, set `buf_v` = 1.
  - If `promo`: also load `ufp_rdata`, increment `pf_hits`, go to RESP.
  - Otherwise go to IDLE. A non-matching `ufp_read` that was waiting is then serviced from IDLE.
  - Clear `promo` and `discard`.

RESP:
- `ufp_resp` = 1 for exactly this cycle.
- `ufp_read` is ignored in this cycle. Next state is IDLE.

`pf_flush`:
- Clears `pend_v` and `buf_v` in the same edge.
- In PREFETCH, also sets `discard`.
- A promoted demand is still answered.
- `pf_flush` and `prefetch_valid` in the same cycle: the flush wins and the request is dropped.

Counters saturate at all-ones. They are never wrapped.

## Timing
- Reset (`rst_n` low, any cycle):
  - State IDLE; all outputs 0; `pend_v`, `buf_v`, `promo`, `discard` = 0; counters = 0.
  - An outstanding memory read is abandoned. The memory adapter is reset by the same `rst_n`.
- Buffer hit: `ufp_read` sampled in IDLE at cycle N → `ufp_resp` at N+1.
- Demand miss:
  - `ufp_read` at N → `dfp_read` high from N+1.
  - `dfp_resp` at M → `ufp_resp` at M+1.
- Prefetch: `prefetch_valid` at N → `pend_v` at N+1 → `dfp_read` from N+2, provided the FSM is IDLE with no `ufp_read` at N+1.
- `dfp_read` and `dfp_addr` are Moore outputs. They are stable from state entry until the `dfp_resp` cycle and deassert the cycle after `dfp_resp`.
- `dfp_resp` outside DEMAND/PREFETCH is ignored.

## Test plan
- Demand miss:
  - Stimulus: `ufp_read`, `ufp_addr`=0x6000_0044; memory answers 3 cycles later with pattern A.
  - Response: `dfp_addr`=0x6000_0040; `ufp_resp` with A one cycle after `dfp_resp`; `buf_v` stays 0.
- Prefetch then hit:
  - Stimulus: `prefetch_pc`=0x6000_0060 pulsed, response B; later `ufp_read` at 0x6000_0068.
  - Response: `pf_issued`=1; `ufp_resp` one cycle after `ufp_read` with B, no `dfp_read`; `pf_hits`=1.
- Promotion:
  - Stimulus: prefetch of 0x6000_0080 in flight; `ufp_read` at 0x6000_0084 mid-flight.
  - Response: a single `dfp_read`; `ufp_resp` one cycle after `dfp_resp`; buffer holds 0x6000_0080.
- Flush during prefetch:
  - Stimulus: `pf_flush` while prefetching 0x6000_00A0.
  - Response: read completes; `buf_v`=0; a following `ufp_read` at 0x6000_00A0 issues a new `dfp_read`.
- Priority and overwrite:
  - Stimulus: `prefetch_valid` for 0x100 then 0x120 while in DEMAND.
  - Response: after `ufp_resp`, only 0x120 is prefetched.
- Async reset:
  - Stimulus: `rst_n` low mid-PREFETCH, asynchronously between edges.
  - Response: `dfp_read`, `ufp_resp`, and both counters go to 0 immediately; state returns to IDLE.
